// File: rtl/ddc_pkg.sv
// Shared DDC definitions: channel-index width helper and {Q,I} packing order.
package ddc_pkg;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed I/Q words always carry Q in the upper half, I in the lower half.
    typedef enum logic {COMP_I = 1'b0, COMP_Q = 1'b1} comp_e;

    localparam int IN_W_DEF  = 16;
    localparam int ACC_W_DEF = 40;

    typedef struct packed {
        logic signed [IN_W_DEF-1:0] q;
        logic signed [IN_W_DEF-1:0] i;
    } iq_smp_t;

    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] q;
        logic signed [ACC_W_DEF-1:0] i;
    } iq_acc_t;

endpackage

// File: rtl/ddc_acc_ram.sv
// Per-channel accumulator store: simple dual-port, registered read, no reset.
module ddc_acc_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 80,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end

endmodule

// File: rtl/ddc_accum_mc.sv
// Multi-channel decimating I/Q accumulator with index-sequence checking.
module ddc_accum_mc
    import ddc_pkg::*;
#(
    parameter int N_CH    = 128,
    parameter int IN_W    = 16,
    parameter int ACC_W   = 40,
    parameter int DECIM_W = 16,
    localparam int CH_W   = ch_w(N_CH)
) (
    input  logic               dev_clk,
    input  logic               dev_rstn,
    input  logic               en,
    input  logic [DECIM_W-1:0] decim,
    input  logic [5:0]         shift,
    input  logic [2*IN_W-1:0]  data_in,
    input  logic [CH_W-1:0]    index_in,
    input  logic               valid_in,
    output logic [2*ACC_W-1:0] data_out,
    output logic [CH_W-1:0]    index_out,
    output logic               valid_out,
    output logic               sync_err
);

    localparam int              STAGES   = 1;
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(N_CH - 1);
    localparam logic [5:0]      MAX_SH   = 6'(ACC_W - 1);

    typedef struct packed {
        logic [IN_W-1:0] q;
        logic [IN_W-1:0] i;
        logic [CH_W-1:0] idx;
        logic            first;
        logic            dump;
        logic [5:0]      sh;
    } stg_t;

    logic [CH_W-1:0]    exp_idx;
    logic [DECIM_W-1:0] frm, decim_l, frm_last, decim_n;
    logic [5:0]         shift_l, shift_n;
    logic               hit, miss;
    logic [STAGES:0]    vld_pipe;
    stg_t               s1;

    logic [2*ACC_W-1:0]       rd_data, wr_data;
    logic signed [ACC_W-1:0]  base_i, base_q, smp_i, smp_q, sum_i, sum_q;

    assign decim_n  = (decim == '0) ? DECIM_W'(1) : decim;
    assign shift_n  = (shift > MAX_SH) ? MAX_SH : shift;
    assign frm_last = decim_l - DECIM_W'(1);
    assign hit      = en & valid_in & (index_in == exp_idx);
    assign miss     = en & valid_in & (index_in != exp_idx);

    // Sequence tracking; decim/shift are only re-latched at period boundaries.
    always_ff @(posedge dev_clk) begin
        if (!dev_rstn || !en) begin
            exp_idx  <= '0;
            frm      <= '0;
            decim_l  <= decim_n;
            shift_l  <= shift_n;
            sync_err <= 1'b0;
        end else if (miss) begin
            exp_idx  <= '0;
            frm      <= '0;
            decim_l  <= decim_n;
            shift_l  <= shift_n;
            sync_err <= 1'b1;
        end else if (hit) begin
            if (exp_idx == LAST_IDX) begin
                exp_idx <= '0;
                if (frm == frm_last) begin
                    frm     <= '0;
                    decim_l <= decim_n;
                    shift_l <= shift_n;
                end else begin
                    frm <= frm + DECIM_W'(1);
                end
            end else begin
                exp_idx <= exp_idx + CH_W'(1);
            end
        end
    end

    ddc_acc_ram #(
        .DEPTH (N_CH),
        .WIDTH (2*ACC_W),
        .AW    (CH_W)
    ) u_ram (
        .clk (dev_clk),
        .we  (vld_pipe[0]),
        .wa  (s1.idx),
        .wd  (wr_data),
        .ra  (index_in),
        .rd  (rd_data)
    );

    // Frame 0 overwrites, so stale RAM contents never leak into a new period.
    always_comb begin
        smp_i   = ACC_W'($signed(s1.i));
        smp_q   = ACC_W'($signed(s1.q));
        base_i  = s1.first ? '0 : $signed(rd_data[ACC_W-1:0]);
        base_q  = s1.first ? '0 : $signed(rd_data[2*ACC_W-1:ACC_W]);
        sum_i   = base_i + smp_i;
        sum_q   = base_q + smp_q;
        wr_data = {sum_q, sum_i};
    end

    always_ff @(posedge dev_clk) begin
        if (!dev_rstn) begin
            vld_pipe  <= '0;
            s1        <= '0;
            data_out  <= '0;
            index_out <= '0;
        end else begin
            vld_pipe[0] <= hit;
            vld_pipe[1] <= vld_pipe[0] & s1.dump;
            if (hit) begin
                s1.q     <= data_in[2*IN_W-1:IN_W];
                s1.i     <= data_in[IN_W-1:0];
                s1.idx   <= index_in;
                s1.first <= (frm == '0);
                s1.dump  <= (frm == frm_last);
                s1.sh    <= shift_l;
            end
            if (vld_pipe[0] && s1.dump) begin
                data_out  <= {sum_q >>> s1.sh, sum_i >>> s1.sh};
                index_out <= s1.idx;
            end
        end
    end

    assign valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_ddc_accum_mc.sv
// Directed bench for ddc_accum_mc with N_CH=4, IN_W=16, ACC_W=40.
module tb_ddc_accum_mc;

    logic        dev_clk = 1'b0;
    logic        dev_rstn, en, valid_in;
    logic [15:0] decim;
    logic [5:0]  shift;
    logic [31:0] data_in;
    logic [1:0]  index_in;
    logic [79:0] data_out;
    logic [1:0]  index_out;
    logic        valid_out, sync_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [79:0] res_dat[$];
    int          res_idx[$];
    int          res_cyc[$];
    int          drv_cyc[$];

    ddc_accum_mc #(.N_CH(4), .IN_W(16), .ACC_W(40), .DECIM_W(16)) dut (
        .dev_clk   (dev_clk),
        .dev_rstn  (dev_rstn),
        .en        (en),
        .decim     (decim),
        .shift     (shift),
        .data_in   (data_in),
        .index_in  (index_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .index_out (index_out),
        .valid_out (valid_out),
        .sync_err  (sync_err)
    );

    always #5 dev_clk = ~dev_clk;
    always @(posedge dev_clk) cyc <= cyc + 1;

    always @(negedge dev_clk) begin
        if (valid_out) begin
            res_dat.push_back(data_out);
            res_idx.push_back(int'(index_out));
            res_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] expd);
        n_chk++;
        if (got !== expd) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, expd);
        end
    endtask

    function automatic logic [79:0] pk(input longint i, input longint q);
        return {q[39:0], i[39:0]};
    endfunction

    task automatic send(input int idx, input int i, input int q);
        @(negedge dev_clk);
        valid_in = 1'b1;
        index_in = 2'(idx);
        data_in  = {q[15:0], i[15:0]};
        drv_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge dev_clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic frame(input int i, input int q);
        for (int k = 0; k < 4; k++) send(k, i, q);
    endtask

    task automatic rearm();
        @(negedge dev_clk);
        valid_in = 1'b0;
        en       = 1'b0;
        @(negedge dev_clk);
        en = 1'b1;
    endtask

    task automatic clr();
        res_dat.delete();
        res_idx.delete();
        res_cyc.delete();
        drv_cyc.delete();
    endtask

    // Results from position first onward are expected in channel order 0..3.
    task automatic chk_res(input string tag, input int first, input int n, input logic [79:0] expd);
        for (int k = first; k < first + n && k < res_dat.size(); k++) begin
            chk($sformatf("%s_dat%0d", tag, k), res_dat[k], expd);
            chk($sformatf("%s_idx%0d", tag, k), 80'(res_idx[k]), 80'((k - first) % 4));
        end
    endtask

    initial begin
        dev_rstn = 1'b0;
        en       = 1'b1;
        valid_in = 1'b0;
        decim    = 16'd1;
        shift    = 6'd0;
        data_in  = '0;
        index_in = '0;
        repeat (3) @(negedge dev_clk);
        chk("rst_valid", 80'(valid_out), 80'(0));
        chk("rst_data",  data_out, 80'(0));
        chk("rst_index", 80'(index_out), 80'(0));
        chk("rst_sync",  80'(sync_err), 80'(0));
        dev_rstn = 1'b1;

        // decim=1: every sample passes straight through, two cycles later
        clr();
        frame(100, -5);
        idle(4);
        chk("s1_cnt", 80'(res_dat.size()), 80'(4));
        chk_res("s1", 0, 4, pk(100, -5));
        for (int k = 0; k < 4 && k < res_cyc.size(); k++)
            chk($sformatf("s1_lat%0d", k), 80'(res_cyc[k] - drv_cyc[k]), 80'(2));

        // decim=4: one result per channel every fourth frame
        decim = 16'd4;
        rearm();
        clr();
        for (int f = 0; f < 12; f++) begin
            frame(1000, -1000);
            idle(4);
            chk($sformatf("s2_cnt_f%0d", f), 80'(res_dat.size()), 80'(4 * ((f + 1) / 4)));
        end
        chk_res("s2", 0, 12, pk(4000, -4000));

        // shift=2, changed to 0 mid-period: takes effect from the next period
        shift = 6'd2;
        rearm();
        clr();
        frame(1000, -1000);
        frame(1000, -1000);
        shift = 6'd0;
        for (int f = 2; f < 8; f++) frame(1000, -1000);
        idle(4);
        chk("s3_cnt", 80'(res_dat.size()), 80'(8));
        chk_res("s3a", 0, 4, pk(1000, -1000));
        chk_res("s3b", 4, 4, pk(4000, -4000));

        // long period of full-scale negative samples
        decim = 16'd1024;
        rearm();
        clr();
        for (int n = 0; n < 4096; n++) send(n % 4, -32768, -32768);
        idle(4);
        chk("s4_cnt", 80'(res_dat.size()), 80'(4));
        chk_res("s4", 0, 4, pk(-33554432, -33554432));

        // decim=0 acts as 1; oversize shift saturates to 39
        decim = 16'd0;
        shift = 6'd63;
        rearm();
        clr();
        frame(100, -32768);
        idle(4);
        chk("s4z_cnt", 80'(res_dat.size()), 80'(4));
        chk_res("s4z", 0, 4, pk(0, -1));

        // sequence error: 0,1,3 then resync on index 0
        decim = 16'd1;
        shift = 6'd0;
        rearm();
        clr();
        send(0, 10, 20);
        send(1, 10, 20);
        decim = 16'd4;
        send(3, 10, 20);
        idle(1);
        chk("s5_sync_set", 80'(sync_err), 80'(1));
        send(1, 10, 20);
        send(2, 10, 20);
        idle(4);
        chk("s5_cnt_err", 80'(res_dat.size()), 80'(2));
        chk_res("s5a", 0, 2, pk(10, 20));
        for (int f = 0; f < 3; f++) frame(7, 3);
        idle(4);
        chk("s5_cnt_3f", 80'(res_dat.size()), 80'(2));
        frame(7, 3);
        idle(4);
        chk("s5_cnt_4f", 80'(res_dat.size()), 80'(6));
        chk_res("s5b", 2, 4, pk(28, 12));
        chk("s5_sync_hold", 80'(sync_err), 80'(1));
        rearm();
        chk("s5_sync_clr", 80'(sync_err), 80'(0));

        // reset with a dump sample in flight
        rearm();
        clr();
        for (int f = 0; f < 3; f++) frame(5, -5);
        send(0, 5, -5);
        @(negedge dev_clk);
        valid_in = 1'b0;
        dev_rstn = 1'b0;
        @(negedge dev_clk);
        chk("s6_rst_valid", 80'(valid_out), 80'(0));
        chk("s6_rst_data",  data_out, 80'(0));
        chk("s6_rst_index", 80'(index_out), 80'(0));
        @(negedge dev_clk);
        chk("s6_rst_cnt", 80'(res_dat.size()), 80'(0));
        dev_rstn = 1'b1;
        for (int f = 0; f < 3; f++) frame(5, -5);
        idle(4);
        chk("s6_cnt_3f", 80'(res_dat.size()), 80'(0));
        frame(5, -5);
        idle(4);
        chk("s6_cnt_4f", 80'(res_dat.size()), 80'(4));
        chk_res("s6", 0, 4, pk(20, -20));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
